exibidor_jogadas: RTL and testbench
===================================

// Module: exibidor_jogadas
// PURPOSE
//  Presenter side of the memory game: holds the target move sequence, plays the first N moves on the
//  LEDs with fixed on/off timing, then serves expected moves by index to the move comparator.
//  Sits between the sequence loader (write port) and the LED outputs / comparator (read port).
// PARAMETERS
//  MAX_LEN    16   sequence depth (moves); power of two, >=2
//  TICKS_ON   500  clock cycles each move is lit
//  TICKS_OFF  250  clock cycles dark gap after each move
//  W          4    move width (one-hot, one bit per LED/button)
// PORTS
//  clock      in   1                   single clock, all logic rising-edge
//  reset      in   1                   synchronous, active-high
//  iniciar    in   1                   start playback (sampled in IDLE only)
//  tamanho    in   $clog2(MAX_LEN)+1   moves to play, sampled with iniciar
//  wr_en      in   1                   sequence write enable
//  wr_addr    in   $clog2(MAX_LEN)     write index
//  wr_data    in   W                   move to store
//  rd_addr    in   $clog2(MAX_LEN)     comparator read index
//  esperada   out  W                   mem[rd_addr], registered
//  leds       out  W                   displayed move, registered
//  exibindo   out  1                   high while playback active (ON/OFF states)
//  pronto     out  1                   one-cycle pulse at end of playback
// BEHAVIOUR
//  Reset: state=IDLE, leds=0, esperada=0, exibindo=0, pronto=0, counters=0. Memory NOT cleared.
//  FSM: IDLE -> ON -> OFF -> (ON | FIM) ; FIM -> IDLE.
//   IDLE: iniciar=1 latches n=min(tamanho,MAX_LEN), idx=0, tick=0. n=0 -> FIM directly (no LEDs).
//         else -> ON.
//   ON:   leds=mem[idx] for exactly TICKS_ON cycles, exibindo=1; tick wraps to 0 -> OFF.
//   OFF:  leds=0 for exactly TICKS_OFF cycles, exibindo=1; then idx==n-1 -> FIM, else idx++ -> ON.
//   FIM:  pronto=1 for one cycle, leds=0, exibindo=0; -> IDLE.
//  Timing: iniciar high at edge k -> leds valid from edge k+1; pronto asserted
//   n*(TICKS_ON+TICKS_OFF) cycles after that (n=0: pronto at edge k+1).
//  leds value for move idx is captured at ON entry and held stable for the whole ON window.
//  iniciar outside IDLE ignored; tamanho changes after capture ignored.
//  Write port: active in every state. Same-cycle write to the address being captured -> old data
//   displayed (read-before-write). Write then read same addr: esperada shows new data 1 cycle
//   after the write edge.
//  esperada: 1-cycle registered latency from rd_addr; independent of FSM state.
//  reset mid-playback: next cycle IDLE, leds=0, exibindo=0, no pronto pulse; memory retained.
//  Counters: tick width $clog2(max(TICKS_ON,TICKS_OFF)); idx width $clog2(MAX_LEN), no overflow
//   since n<=MAX_LEN. Any undefined state encoding -> IDLE.
// STRUCTURE
//  Shared package/include (jogadas_defs): state encoding (IDLE,ON,OFF,FIM), W, one-hot move constants.
//  Sub-module ram_jogadas: MAX_LEN x W, 1 write port, 2 sync read ports (display, comparator).
//  FSM, tick counter and idx counter in this module.
// TESTING (bench params: MAX_LEN=4, TICKS_ON=3, TICKS_OFF=2)
//  1 Load mem={0001,0010,0100,1000}, tamanho=3, pulse iniciar -> leds 0001x3,0000x2,0010x3,0000x2,
//    0100x3,0000x2; pronto pulse at cycle 16 after iniciar; exibindo high cycles 1..15.
//  2 tamanho=0, iniciar -> pronto next cycle, leds stay 0000, exibindo never high.
//  3 tamanho=7 (>MAX_LEN) -> exactly 4 moves shown, pronto after 20 cycles.
//  4 reset asserted during second ON window -> next cycle leds=0, exibindo=0, no pronto; then
//    rd_addr=2 -> esperada=0100 (memory retained).
//  5 iniciar re-pulsed mid-playback -> sequence and timing of test 1 unchanged.
//  6 wr_en to addr 1 with 1000 during move 0 ON -> move 1 shows 1000; rd_addr=1 next cycle -> 1000.

Source files
------------

// File: rtl/exibidor_jogadas_pkg.sv
// Shared definitions for the memory-game presenter: FSM encoding, move width
// and the one-hot move constants.
package jogadas_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        FIM  = 2'd3
    } estado_t;

    localparam int W_JOGADA = 4;

    localparam logic [W_JOGADA-1:0] JOG_0 = 4'b0001;
    localparam logic [W_JOGADA-1:0] JOG_1 = 4'b0010;
    localparam logic [W_JOGADA-1:0] JOG_2 = 4'b0100;
    localparam logic [W_JOGADA-1:0] JOG_3 = 4'b1000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/exibidor_jogadas_if.sv
// Control, sequence-write and comparator-read bundle of the presenter.
interface exibidor_jogadas_if #(
    parameter int MAX_LEN = 16,
    parameter int W       = 4
);
    localparam int AW = $clog2(MAX_LEN);

    logic          iniciar;
    logic [AW:0]   tamanho;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  esperada;
    logic [W-1:0]  leds;
    logic          exibindo;
    logic          pronto;

    modport master (
        output iniciar, tamanho, wr_en, wr_addr, wr_data, rd_addr,
        input  esperada, leds, exibindo, pronto
    );

    modport slave (
        input  iniciar, tamanho, wr_en, wr_addr, wr_data, rd_addr,
        output esperada, leds, exibindo, pronto
    );
endinterface

// File: rtl/exibidor_jogadas_ram.sv
// Move-sequence storage: one write port, two registered read ports
// (display and comparator). Reads return the pre-write contents.
module ram_jogadas #(
    parameter int MAX_LEN = 16,
    parameter int W       = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wr_en_i,
    input  logic [$clog2(MAX_LEN)-1:0] wr_addr_i,
    input  logic [W-1:0]               wr_data_i,
    input  logic [$clog2(MAX_LEN)-1:0] rd0_addr_i,
    output logic [W-1:0]               rd0_data_o,
    input  logic [$clog2(MAX_LEN)-1:0] rd1_addr_i,
    output logic [W-1:0]               rd1_data_o
);
    logic [W-1:0] mem_q [MAX_LEN];
    logic [W-1:0] rd0_q;
    logic [W-1:0] rd1_q;

    // Contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd0_q <= '0;
            rd1_q <= '0;
        end else begin
            rd0_q <= mem_q[rd0_addr_i];
            rd1_q <= mem_q[rd1_addr_i];
        end
    end

    assign rd0_data_o = rd0_q;
    assign rd1_data_o = rd1_q;
endmodule

// File: rtl/exibidor_jogadas.sv
// Memory-game presenter: plays the first n stored moves on the LEDs with fixed
// on/off timing and serves stored moves to the comparator by index.
module exibidor_jogadas
    import jogadas_defs::*;
#(
    parameter int MAX_LEN   = 16,
    parameter int TICKS_ON  = 500,
    parameter int TICKS_OFF = 250,
    parameter int W         = W_JOGADA
) (
    input  logic                clock,
    input  logic                reset,
    exibidor_jogadas_if.slave   bus
);
    localparam int AW   = $clog2(MAX_LEN);
    localparam int TMAX = max_int(TICKS_ON, TICKS_OFF);
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] ON_LAST  = TW'(TICKS_ON - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(TICKS_OFF - 1);
    localparam logic [AW:0]   MAX_N    = (AW+1)'(MAX_LEN);

    estado_t       state_q;
    logic [TW-1:0] tick_q;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW:0]   n_q;
    logic [W-1:0]  leds_q;
    logic          exibindo_q;
    logic          pronto_q;
    logic [W-1:0]  disp_data;
    logic          last_move;

    assign last_move = ({1'b0, idx_q} == (n_q - 1'b1));

    // The display port is addressed with the next index so the move is
    // already sitting in the read register when the ON window opens.
    always_comb begin
        idx_d = idx_q;
        if (state_q == IDLE && bus.iniciar) begin
            idx_d = '0;
        end else if (state_q == OFF && tick_q == OFF_LAST && !last_move) begin
            idx_d = idx_q + 1'b1;
        end
    end

    ram_jogadas #(
        .MAX_LEN (MAX_LEN),
        .W       (W)
    ) u_ram (
        .clock      (clock),
        .reset      (reset),
        .wr_en_i    (bus.wr_en),
        .wr_addr_i  (bus.wr_addr),
        .wr_data_i  (bus.wr_data),
        .rd0_addr_i (idx_d),
        .rd0_data_o (disp_data),
        .rd1_addr_i (bus.rd_addr),
        .rd1_data_o (bus.esperada)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            idx_q      <= '0;
            n_q        <= '0;
            leds_q     <= '0;
            exibindo_q <= 1'b0;
            pronto_q   <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            pronto_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    leds_q     <= '0;
                    exibindo_q <= 1'b0;
                    tick_q     <= '0;
                    if (bus.iniciar) begin
                        n_q     <= (bus.tamanho > MAX_N) ? MAX_N : bus.tamanho;
                        state_q <= (bus.tamanho == '0) ? FIM : ON;
                    end
                end
                ON: begin
                    exibindo_q <= 1'b1;
                    if (tick_q == '0) begin
                        leds_q <= disp_data;
                    end
                    if (tick_q == ON_LAST) begin
                        tick_q  <= '0;
                        state_q <= OFF;
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                OFF: begin
                    exibindo_q <= 1'b1;
                    leds_q     <= '0;
                    if (tick_q == OFF_LAST) begin
                        tick_q  <= '0;
                        state_q <= last_move ? FIM : ON;
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                FIM: begin
                    leds_q     <= '0;
                    exibindo_q <= 1'b0;
                    pronto_q   <= 1'b1;
                    state_q    <= IDLE;
                end
                default: begin
                    leds_q     <= '0;
                    exibindo_q <= 1'b0;
                    tick_q     <= '0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign bus.leds     = leds_q;
    assign bus.exibindo = exibindo_q;
    assign bus.pronto   = pronto_q;
endmodule

// File: tb/tb_exibidor_jogadas.sv
// Directed bench for exibidor_jogadas with short on/off windows.
module tb_exibidor_jogadas;
    import jogadas_defs::*;

    localparam int ML   = 4;
    localparam int TON  = 3;
    localparam int TOFF = 2;
    localparam int PER  = TON + TOFF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exibidor_jogadas_if #(.MAX_LEN(ML), .W(4)) bus ();

    exibidor_jogadas #(
        .MAX_LEN   (ML),
        .TICKS_ON  (TON),
        .TICKS_OFF (TOFF),
        .W         (4)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] memv [ML];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs();
        return {26'd0, bus.pronto, bus.exibindo, bus.leds};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [3:0] d);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a[1:0];
        bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
        memv[a]   = d;
    endtask

    task automatic rd(input string tag, input int a, input logic [3:0] exp);
        @(negedge clk);
        bus.rd_addr = a[1:0];
        tick();
        chk(tag, {28'd0, bus.esperada}, {28'd0, exp});
    endtask

    // Expected timeline: moves lit in cycles 1..3 of each 5-cycle slot,
    // pronto in the cycle after the last slot.
    task automatic play(input string tag, input int tam, input int nexp,
                        input int repulse, input int wr_at);
        int total;
        int m;
        int p;
        logic [31:0] e;
        total = (nexp == 0) ? 1 : nexp * PER + 1;
        @(negedge clk);
        bus.iniciar = 1'b1;
        bus.tamanho = 3'(tam);
        tick();
        bus.iniciar = 1'b0;
        chk($sformatf("%s c0", tag), obs(), 32'd0);
        for (int j = 1; j <= total; j++) begin
            if (j == repulse) begin
                @(negedge clk);
                bus.iniciar = 1'b1;
                bus.tamanho = 3'd1;
            end
            if (j == wr_at) begin
                @(negedge clk);
                bus.wr_en   = 1'b1;
                bus.wr_addr = 2'd1;
                bus.wr_data = JOG_3;
            end
            tick();
            bus.iniciar = 1'b0;
            if (bus.wr_en) begin
                bus.wr_en = 1'b0;
                memv[1]   = JOG_3;
            end
            if (j == total) begin
                e = 32'h20;
            end else begin
                m = (j - 1) / PER;
                p = (j - 1) % PER;
                e = {26'd0, 2'b01, (p < TON) ? memv[m] : 4'b0000};
            end
            chk($sformatf("%s c%0d", tag, j), obs(), e);
        end
        tick();
        chk($sformatf("%s idle", tag), obs(), 32'd0);
    endtask

    initial begin
        logic bad;
        rst         = 1'b1;
        bus.iniciar = 1'b0;
        bus.tamanho = '0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_addr = '0;
        repeat (3) tick();
        chk("rst outs", obs(), 32'd0);
        chk("rst esperada", {28'd0, bus.esperada}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        wr(0, JOG_0);
        wr(1, JOG_1);
        wr(2, JOG_2);
        wr(3, JOG_3);
        rd("rd0", 0, 4'b0001);
        rd("rd1", 1, 4'b0010);
        rd("rd2", 2, 4'b0100);
        rd("rd3", 3, 4'b1000);

        play("t1", 3, 3, 0, 0);
        play("t2", 0, 0, 0, 0);
        play("t3", 7, 4, 0, 0);
        play("t5", 3, 3, 7, 0);
        play("t6", 3, 3, 0, 2);
        rd("t6 rd1", 1, 4'b1000);

        // Reset in the middle of the second ON window.
        @(negedge clk);
        bus.iniciar = 1'b1;
        bus.tamanho = 3'd3;
        tick();
        bus.iniciar = 1'b0;
        repeat (6) tick();
        chk("t4 move1", obs(), {26'd0, 2'b01, 4'b1000});
        @(negedge clk);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4 after rst", obs(), 32'd0);
        bad = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (bus.pronto || bus.exibindo || bus.leds != 4'b0) bad = 1'b1;
        end
        chk("t4 quiet", {31'd0, bad}, 32'd0);
        rd("t4 mem kept", 2, 4'b0100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
